// File: rtl/brr_pkg.sv
// brr_pkg: shared state encoding, BRR header field positions and block geometry.
package brr_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_REQ,
      S_DATA_REQ,
      S_FILT,
      S_RESULT,
      S_EMIT
   } state_e;

   localparam int SHIFT_MSB = 7;
   localparam int SHIFT_LSB = 4;
   localparam int FILT_MSB  = 3;
   localparam int FILT_LSB  = 2;
   localparam int LOOP_BIT  = 1;
   localparam int END_BIT   = 0;

   localparam int BLOCK_BYTES       = 9;
   localparam int SAMPLES_PER_BLOCK = 2 * (BLOCK_BYTES - 1);

   localparam logic [15:0] SHIFT_CLAMP_VAL = 16'hF800;
endpackage

// File: rtl/brr_nibble_scale.sv
// brr_nibble_scale: sign-extends a BRR nibble and applies the header shift (halved), clamping shifts 13..15.
module brr_nibble_scale
   import brr_pkg::*;
(
   input  logic [3:0]  nibble,
   input  logic [3:0]  shift,
   output logic [15:0] scaled
);
   logic [15:0] shifted;

   always_comb begin
      shifted = {{12{nibble[3]}}, nibble} << shift;
      scaled  = (shift > 4'd12) ? (nibble[3] ? SHIFT_CLAMP_VAL : 16'h0000)
                                : {shifted[15], shifted[15:1]};
   end
endmodule

// File: rtl/brr_block_sequencer.sv
// brr_block_sequencer: fetches 9-byte BRR blocks, drives the shared prediction filter and streams samples.
// Define BRR_LOOP_EN to make end blocks with the loop flag jump to loop_addr instead of stopping.
module brr_block_sequencer
   import brr_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] start_addr,
   input  logic [15:0] loop_addr,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic [1:0]  filt_type,
   output logic [15:0] filt_s0,
   output logic [15:0] filt_s1,
   output logic [15:0] filt_s2,
   input  logic [15:0] filt_result,
   output logic        out_valid,
   output logic [15:0] out_sample,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        loop_hit
);
   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  hdr_q, hdr_d;
   logic [3:0]  lo_q, lo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] h1_q, h1_d, h2_q, h2_d;
   logic        mem_req_q, mem_req_d;
   logic [1:0]  filt_type_q, filt_type_d;
   logic [15:0] filt_s0_q, filt_s0_d, filt_s1_q, filt_s1_d, filt_s2_q, filt_s2_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_sample_q, out_sample_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [3:0]  nib;
   logic [15:0] scaled;

   // The high nibble is scaled straight off the bus during the ack; the low nibble comes from the saved byte.
   assign nib = (state_q == S_DATA_REQ) ? mem_data[7:4] : lo_q;

   brr_nibble_scale u_scale (
      .nibble (nib),
      .shift  (hdr_q[SHIFT_MSB:SHIFT_LSB]),
      .scaled (scaled)
   );

`ifdef BRR_LOOP_EN
   logic [15:0] loop_q, loop_d;
   logic        loop_hit_q, loop_hit_d;
   assign loop_hit = loop_hit_q;
`else
   logic unused_loop;
   assign unused_loop = ^{loop_addr, hdr_q[LOOP_BIT]};
   assign loop_hit    = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      hdr_d        = hdr_q;
      lo_d         = lo_q;
      cnt_d        = cnt_q;
      h1_d         = h1_q;
      h2_d         = h2_q;
      mem_req_d    = mem_req_q;
      filt_type_d  = filt_type_q;
      filt_s0_d    = filt_s0_q;
      filt_s1_d    = filt_s1_q;
      filt_s2_d    = filt_s2_q;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      done_d       = 1'b0;
`ifdef BRR_LOOP_EN
      loop_d       = loop_q;
      loop_hit_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE:
            if (start && !stop) begin
               addr_d  = start_addr;
               h1_d    = 16'h0000;
               h2_d    = 16'h0000;
               state_d = S_HDR_REQ;
`ifdef BRR_LOOP_EN
               loop_d  = loop_addr;
`endif
            end
         S_HDR_REQ:
            if (mem_req_q && mem_ack) begin
               hdr_d     = mem_data;
               addr_d    = addr_q + 16'd1;
               mem_req_d = 1'b0;
               cnt_d     = 4'd0;
               state_d   = S_DATA_REQ;
            end else begin
               mem_req_d = 1'b1;
            end
         S_DATA_REQ:
            if (mem_req_q && mem_ack) begin
               lo_d        = mem_data[3:0];
               addr_d      = addr_q + 16'd1;
               mem_req_d   = 1'b0;
               filt_type_d = hdr_q[FILT_MSB:FILT_LSB];
               filt_s0_d   = scaled;
               filt_s1_d   = h1_q;
               filt_s2_d   = h2_q;
               state_d     = S_FILT;
            end else begin
               mem_req_d = 1'b1;
            end
         S_FILT:
            state_d = S_RESULT;
         S_RESULT: begin
            out_sample_d = filt_result;
            out_valid_d  = 1'b1;
            h2_d         = h1_q;
            h1_d         = filt_result;
            state_d      = S_EMIT;
         end
         S_EMIT:
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = cnt_q + 4'd1;
               if (!cnt_q[0]) begin
                  filt_s0_d = scaled;
                  filt_s1_d = h1_q;
                  filt_s2_d = h2_q;
                  state_d   = S_FILT;
               end else if (cnt_q != 4'(SAMPLES_PER_BLOCK - 1)) begin
                  state_d = S_DATA_REQ;
               end else if (!hdr_q[END_BIT]) begin
                  state_d = S_HDR_REQ;
`ifdef BRR_LOOP_EN
               end else if (hdr_q[LOOP_BIT]) begin
                  addr_d     = loop_q;
                  loop_hit_d = 1'b1;
                  state_d    = S_HDR_REQ;
`endif
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         default:
            state_d = S_IDLE;
      endcase
      if (stop) begin
         state_d     = S_IDLE;
         mem_req_d   = 1'b0;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
`ifdef BRR_LOOP_EN
         loop_hit_d  = 1'b0;
`endif
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         hdr_q        <= '0;
         lo_q         <= '0;
         cnt_q        <= '0;
         h1_q         <= '0;
         h2_q         <= '0;
         mem_req_q    <= 1'b0;
         filt_type_q  <= '0;
         filt_s0_q    <= '0;
         filt_s1_q    <= '0;
         filt_s2_q    <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef BRR_LOOP_EN
         loop_q       <= '0;
         loop_hit_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         hdr_q        <= hdr_d;
         lo_q         <= lo_d;
         cnt_q        <= cnt_d;
         h1_q         <= h1_d;
         h2_q         <= h2_d;
         mem_req_q    <= mem_req_d;
         filt_type_q  <= filt_type_d;
         filt_s0_q    <= filt_s0_d;
         filt_s1_q    <= filt_s1_d;
         filt_s2_q    <= filt_s2_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef BRR_LOOP_EN
         loop_q       <= loop_d;
         loop_hit_q   <= loop_hit_d;
`endif
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_addr   = addr_q;
   assign filt_type  = filt_type_q;
   assign filt_s0    = filt_s0_q;
   assign filt_s1    = filt_s1_q;
   assign filt_s2    = filt_s2_q;
   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule

// File: tb/tb_brr_block_sequencer.sv
// tb_brr_block_sequencer: random BRR streams checked against a block-level reference decoder via sample/address scoreboards.
module tb_brr_block_sequencer;
   logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
   logic [15:0] start_addr = '0, loop_addr = '0;
   logic        mem_req, mem_ack = 1'b0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data = '0;
   logic [1:0]  filt_type;
   logic [15:0] filt_s0, filt_s1, filt_s2, filt_result = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [15:0] out_sample;
   logic        busy, done, loop_hit;

   int checks = 0, errors = 0;
   logic [7:0]  mem [0:65535];
   logic [15:0] exp_smp[$], exp_addr[$], got_smp[$];
   int          exp_loops, done_cnt, loop_cnt, lat_max = 0, wait_cnt = 0, stall_cnt = 0;
   bit          exp_done, mem_manual = 0, ready_rand = 0, stall_arm = 0, stall_seen = 0, stall_bad = 0;
   logic [15:0] stall_smp;

`ifdef BRR_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   brr_block_sequencer dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
      .start_addr(start_addr), .loop_addr(loop_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .filt_type(filt_type), .filt_s0(filt_s0), .filt_s1(filt_s1), .filt_s2(filt_s2),
      .filt_result(filt_result), .out_valid(out_valid), .out_sample(out_sample),
      .out_ready(out_ready), .busy(busy), .done(done), .loop_hit(loop_hit)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Stand-in for the shared prediction filter: any fixed function of the inputs, one-cycle latency.
   function automatic logic [15:0] filt_f(input logic [1:0] t, input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
      logic signed [15:0] a, b, c;
      a = s0; b = s1; c = s2;
      case (t)
         2'd0:    return a;
         2'd1:    return a + (b >>> 1);
         2'd2:    return a + b - (c >>> 1);
         default: return a + (b >>> 1) - (c >>> 2);
      endcase
   endfunction

   function automatic logic [15:0] ref_scale(input logic [3:0] nib, input int sh);
      int n, p;
      logic signed [15:0] p16;
      n = nib[3] ? int'(nib) - 16 : int'(nib);
      if (sh > 12) return (n < 0) ? 16'hF800 : 16'h0000;
      p = n * (1 << sh);
      p16 = p[15:0];
      return p16 >>> 1;
   endfunction

   always @(posedge clock) filt_result <= filt_f(filt_type, filt_s0, filt_s1, filt_s2);

   // Reference decoder: walks memory block by block and predicts every read address and sample.
   task automatic build(input logic [15:0] sa, input logic [15:0] la, input int maxb);
      logic [15:0] a, h1, h2, r;
      logic [7:0]  hdr, b;
      a = sa; h1 = 0; h2 = 0; exp_done = 0; exp_loops = 0;
      for (int blk = 0; blk < maxb; blk++) begin
         hdr = mem[a]; exp_addr.push_back(a); a = a + 16'd1;
         for (int k = 0; k < 8; k++) begin
            b = mem[a]; exp_addr.push_back(a); a = a + 16'd1;
            for (int j = 0; j < 2; j++) begin
               r = filt_f(hdr[3:2], ref_scale(j == 0 ? b[7:4] : b[3:0], int'(hdr[7:4])), h1, h2);
               exp_smp.push_back(r);
               h2 = h1; h1 = r;
            end
         end
         if (hdr[0]) begin
            if (LOOP_EN && hdr[1]) begin
               exp_loops++;
               a = la;
            end else begin
               exp_done = 1;
               break;
            end
         end
      end
   endtask

   always @(negedge clock) begin
      if (!mem_manual) begin
         if (mem_req && !mem_ack) begin
            if (wait_cnt == 0) begin
               mem_ack  = 1'b1;
               mem_data = mem[mem_addr];
               if (exp_addr.size() > 0) chk("read_addr", mem_addr, exp_addr.pop_front());
               wait_cnt = $urandom_range(0, lat_max);
            end else begin
               wait_cnt--;
            end
         end else begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
         end
      end
   end

   always @(negedge clock) begin
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         if (!out_valid || out_sample !== stall_smp || mem_req !== 1'b0) stall_bad = 1;
         stall_cnt--;
      end else if (stall_arm && out_valid) begin
         stall_arm = 0; stall_seen = 1; stall_cnt = 9;
         stall_smp = out_sample;
         out_ready = 1'b0;
      end else begin
         out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
         got_smp.push_back(out_sample);
         if (exp_smp.size() == 0) chk("unexpected_sample", out_sample, 16'hxxxx);
         else chk("sample", out_sample, exp_smp.pop_front());
      end
      if (done) done_cnt++;
      if (loop_hit) loop_cnt++;
   end

   task automatic run(input logic [15:0] sa, input logic [15:0] la, input int maxb, input bit mid);
      int t;
      exp_smp.delete(); exp_addr.delete(); got_smp.delete();
      done_cnt = 0; loop_cnt = 0;
      build(sa, la, maxb);
      @(negedge clock); start_addr = sa; loop_addr = la; start = 1'b1;
      @(negedge clock); start = 1'b0;
      if (mid) begin
         repeat (4) @(negedge clock);
         start_addr = ~sa; loop_addr = ~la; start = 1'b1;
         @(negedge clock); start = 1'b0;
      end
      t = 0;
      while (exp_smp.size() > 0 && t < 20000) begin @(negedge clock); t++; end
      chk("samples_drained", exp_smp.size(), 0);
      if (exp_done) begin
         t = 0;
         while (busy && t < 100) begin @(negedge clock); t++; end
      end else begin
         @(negedge clock); stop = 1'b1;
         @(negedge clock); stop = 1'b0;
      end
      @(negedge clock);
      chk("done_pulses", done_cnt, exp_done);
      chk("loop_pulses", loop_cnt, exp_loops);
      chk("idle_after", busy, 0);
   endtask

   task automatic fill(input logic [15:0] base, input int nblk);
      for (int i = 0; i < nblk * 9; i++) mem[base + 16'(i)] = 8'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bit ok;
      logic [15:0] base;
      int nblk;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sample", out_sample, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_loop_hit", loop_hit, 0);
      chk("rst_filt", {filt_type, filt_s0, filt_s1, filt_s2} == '0, 1);
      @(negedge clock); reset_n = 1'b1;

      // Header 41 / data 7F with zero-latency memory.
      fill(16'h0200, 2);
      mem[16'h0200] = 8'h41; mem[16'h0201] = 8'h7F; mem[16'h0209] = 8'h01;
      lat_max = 0; wait_cnt = 0;
      run(16'h0200, 16'h0000, 4, 0);
      chk("tp1_first", got_smp.size() > 0 ? got_smp[0] : 16'hxxxx, 16'h0038);
      chk("tp1_second", got_smp.size() > 1 ? got_smp[1] : 16'hxxxx, 16'hFFF8);

      // Shift 13 clamp.
      fill(16'h0400, 1);
      mem[16'h0400] = 8'hD1; mem[16'h0401] = 8'h83;
      run(16'h0400, 16'h0000, 1, 0);
      chk("clamp_neg", got_smp.size() > 0 ? got_smp[0] : 16'hxxxx, 16'hF800);
      chk("clamp_pos", got_smp.size() > 1 ? got_smp[1] : 16'hxxxx, 16'h0000);

      // End+loop block, with a plain block at the loop target.
      fill(16'h0300, 1); fill(16'h0100, 1);
      mem[16'h0300] = 8'h03; mem[16'h0100] = 8'h20;
      lat_max = 2;
      run(16'h0300, 16'h0100, 2, 0);

      // Address wrap.
      fill(16'hFFFC, 1);
      mem[16'hFFFC] = 8'h95;
      run(16'hFFFC, 16'h0000, 1, 0);

      // Back-pressure hold with a start pulse issued while busy.
      fill(16'h0800, 2);
      mem[16'h0800] = 8'h7A; mem[16'h0809] = 8'h5D;
      ready_rand = 1; stall_arm = 1; stall_seen = 0; stall_bad = 0;
      run(16'h0800, 16'h1234, 4, 1);
      chk("stall_seen", stall_seen, 1);
      chk("stall_hold", stall_bad, 0);

      // Randomized streams.
      for (int r = 0; r < 8; r++) begin
         base = 16'($urandom); nblk = $urandom_range(1, 4);
         fill(base, nblk);
         for (int b = 0; b < nblk; b++) begin
            mem[base + 16'(b * 9)][0] = (b == nblk - 1);
            if (b == nblk - 1) mem[base + 16'(b * 9)][1] = 1'b0;
         end
         lat_max = $urandom_range(0, 3);
         run(base, 16'($urandom), nblk, r[0]);
      end

      // Stop in the same cycle as a header ack.
      ready_rand = 0; mem_manual = 1; mem_ack = 1'b0;
      exp_smp.delete(); exp_addr.delete();
      @(negedge clock); start_addr = 16'h0500; start = 1'b1;
      @(negedge clock); start = 1'b0;
      t = 0;
      while (!mem_req && t < 20) begin @(negedge clock); t++; end
      chk("stop_req_seen", mem_req, 1);
      mem_ack = 1'b1; mem_data = 8'h41; stop = 1'b1;
      @(posedge clock); #1;
      chk("stop_idle", busy, 0);
      chk("stop_req_low", mem_req, 0);
      @(negedge clock); mem_ack = 1'b0; stop = 1'b0;
      ok = 1;
      repeat (12) begin
         @(negedge clock);
         if (out_valid || mem_req || busy) ok = 0;
      end
      chk("stop_quiet", ok, 1);
      mem_manual = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
